dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the single data RAM (`Data_RAM`) used by the pipeline's MEM stage. Port 0 belongs to the CPU MEM stage and port 1 to a secondary master (DMA/debug loader). Each cycle the arbiter grants at most one port and drives the RAM's write-enable, strobe, address and write-data lines from that port. It registers read data and error status back to the granted port, and bounds port-1 starvation with a wait counter.

## Interface
- STARVE_MAX, 4: consecutive denied cycles after which a pending port-1 request wins over port 0; legal range ≥1.
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset; asynchronous, active-low.
- mN_req  in  1  port N (N=0,1) access request; held until mN_gnt.
- mN_we  in  1  1 = store, 0 = load.
- mN_strb  in  3  access type: 000 SB, 001 SH, 010 SW, 011 LB, 100 LH, 101 LW, 110 LBU, 111 LHU.
- mN_addr  in  32  byte address.
- mN_wdata  in  32  store data, already placed in the target byte lane by the requester.
- mN_gnt  out  1  combinational; access performed this cycle. Port 0 uses !m0_gnt && m0_req as its pipeline stall.
- mN_rvalid  out  1  registered one-cycle pulse; response for the access granted in the previous cycle.
- mN_rdata  out  32  registered load data, valid with mN_rvalid.
- mN_err  out  1  registered misalignment flag, valid with mN_rvalid.
- ram_we  out  1  RAM write enable.
- ram_strb  out  3  RAM access type.
- ram_addr  out  32  RAM byte address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM combinational read data.

## Operation
- Arbitration is combinational within a cycle.
  - Default: port 0 wins whenever m0_req=1.
  - Port 1 wins if m0_req=0, or if m1_req=1 and starve_cnt==STARVE_MAX.
  - At most one mN_gnt is high per cycle.
- starve_cnt: width $clog2(STARVE_MAX+1), saturating.
  - Increments on each cycle with m1_req && !m1_gnt.
  - Clears on m1_gnt or when m1_req=0.
- RAM mux: the granted port drives ram_addr, ram_strb and ram_wdata. ram_we = mN_we && !misaligned.
- No grant: ram_we=0 and ram_addr, ram_strb, ram_wdata are all 0.
- Misaligned access:
  - SH/LH/LHU with addr[0]=1.
  - SW/LW with addr[1:0]≠00.
  - strb 011–111 with we=1 is treated as SW, with the same alignment rule.
  - A misaligned access is still granted and consumes the slot. ram_we is forced 0, and the response carries err=1 with rdata=0.
- Response register, loaded at the edge that ends a grant cycle:
  - rvalid ← 1 for the granted port.
  - rdata ← ram_rdata for an aligned load; 0 for a store or an error.
  - err ← misaligned.
- The non-granted port's rvalid and err are 0. Its rdata holds its last value.
- Stores commit to the RAM at the same edge. A load on the next grant returns the new data (no forwarding required).

## Timing
- Reset (rstn=0, asynchronous):
  - Registered outputs: m0/m1_rvalid=0, m0/m1_rdata=0, m0/m1_err=0, starve_cnt=0.
  - While rstn=0: mN_gnt=0 and ram_we=0, so no RAM write occurs at any edge during reset.
- Latency:
  - Grant: 0 cycles from req, when winning.
  - Response: rvalid exactly 1 cycle after the grant cycle.
- Throughput: one access per cycle total. Back-to-back grants to the same port produce back-to-back rvalid pulses.
- Sustained contention with both requests continuously high:
  - Grant pattern is STARVE_MAX cycles to port 0, then 1 cycle to port 1, repeating with period STARVE_MAX+1.
  - The counter clears on the port-1 grant.
- Simultaneous events: a port-1 forced grant and a new port-0 request in the same cycle give port 1 the grant. Port 0 stalls one cycle with no loss of its request.
- Reset mid-operation: the pending rvalid is cleared. The in-flight write is dropped if rstn is low at the commit edge.
- Request changes while ungranted are legal. The arbiter keeps no per-request state besides starve_cnt.

## Test plan
- Reset: drive all inputs random with rstn=0 → all mN_gnt/rvalid/err=0, rdata=0, ram_we=0. Release; idle → ram_addr=0.
- Port 0 only: SW addr 0x10, wdata 0xDEADBEEF; next cycle LW 0x10 → m0_gnt=1 both cycles, m0_rvalid on cycles 2 and 3, LW rdata=0xDEADBEEF, err=0.
- Byte lanes via port 1: SB addr 0x21, wdata 0x0000A500; LB 0x21 → rdata 0xFFFFFFA5; LBU 0x21 → 0x000000A5.
- Contention, STARVE_MAX=4: hold m0_req=m1_req=1 for 15 cycles → m1_gnt on cycles 5, 10 and 15 only; m0_gnt on all other cycles; never both high.
- Misalignment: m1 LW 0x13 → granted, ram_we=0, next cycle m1_rvalid=1, m1_err=1, rdata=0. m1 SW 0x12, wdata 0x12345678 → word 0x10 is unchanged on readback.
- Reset mid-write: m1 SW 0x40, wdata 0x55; pull rstn low before the edge → m1_rvalid stays 0; after release, LW 0x40 returns the prior contents.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : two-port arbiter/sequencer for the MEM-stage data RAM.
// Revision     : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [2:0]  i_m0_strb,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_err,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [2:0]  i_m1_strb,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_err,
  output logic        o_ram_we,
  output logic [2:0]  o_ram_strb,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  input  logic [31:0] i_ram_rdata
);

  localparam int              c_cnt_w      = $clog2(STARVE_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

  logic [c_cnt_w-1:0] r_starve_cnt;
  logic               r_m0_rvalid, r_m1_rvalid;
  logic               r_m0_err, r_m1_err;
  logic [31:0]        r_m0_rdata, r_m1_rdata;

  logic               w_gnt0, w_gnt1, w_any;
  logic               w_sel_we;
  logic [2:0]         w_sel_strb;
  logic [31:0]        w_sel_addr, w_sel_wdata;
  logic               w_mis;
  logic [31:0]        w_resp_data;

  // Stores carrying a load-type strobe are checked as full words.
  function automatic logic f_misaligned(input logic we, input logic [2:0] strb,
                                        input logic [1:0] a);
    logic [2:0] s;
    s = (we && (strb >= 3'd3)) ? 3'b010 : strb;
    case (s)
      3'b001, 3'b100, 3'b111: return a[0];
      3'b010, 3'b101:         return (a != 2'b00);
      default:                return 1'b0;
    endcase
  endfunction

  // Grants are held off during reset so no RAM write can slip through.
  assign w_gnt1 = rstn && i_m1_req && (!i_m0_req || (r_starve_cnt == c_starve_max));
  assign w_gnt0 = rstn && i_m0_req && !w_gnt1;
  assign w_any  = w_gnt0 || w_gnt1;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_strb  = 3'b000;
    w_sel_addr  = 32'h0;
    w_sel_wdata = 32'h0;
    if (w_gnt1) begin
      w_sel_we    = i_m1_we;
      w_sel_strb  = i_m1_strb;
      w_sel_addr  = i_m1_addr;
      w_sel_wdata = i_m1_wdata;
    end else if (w_gnt0) begin
      w_sel_we    = i_m0_we;
      w_sel_strb  = i_m0_strb;
      w_sel_addr  = i_m0_addr;
      w_sel_wdata = i_m0_wdata;
    end
  end

  assign w_mis       = w_any && f_misaligned(w_sel_we, w_sel_strb, w_sel_addr[1:0]);
  assign w_resp_data = (!w_sel_we && !w_mis) ? i_ram_rdata : 32'h0;

  assign o_m0_gnt    = w_gnt0;
  assign o_m1_gnt    = w_gnt1;
  assign o_ram_we    = w_any && w_sel_we && !w_mis;
  assign o_ram_strb  = w_sel_strb;
  assign o_ram_addr  = w_sel_addr;
  assign o_ram_wdata = w_sel_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_starve_cnt <= '0;
    end else if (!i_m1_req || w_gnt1) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != c_starve_max) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_err    <= 1'b0;
      r_m1_err    <= 1'b0;
      r_m0_rdata  <= 32'h0;
      r_m1_rdata  <= 32'h0;
    end else begin
      r_m0_rvalid <= w_gnt0;
      r_m1_rvalid <= w_gnt1;
      r_m0_err    <= w_gnt0 && w_mis;
      r_m1_err    <= w_gnt1 && w_mis;
      if (w_gnt0) r_m0_rdata <= w_resp_data;
      if (w_gnt1) r_m1_rdata <= w_resp_data;
    end
  end

  assign o_m0_rvalid = r_m0_rvalid;
  assign o_m1_rvalid = r_m1_rvalid;
  assign o_m0_err    = r_m0_err;
  assign o_m1_err    = r_m1_err;
  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_rdata  = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed + random bench with a byte-level memory model.
// Revision        : 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req[2];
  logic        we[2];
  logic [2:0]  strb[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [2:0]  ram_strb;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .rstn(rstn),
    .i_m0_req(req[0]), .i_m0_we(we[0]), .i_m0_strb(strb[0]),
    .i_m0_addr(addr[0]), .i_m0_wdata(wdata[0]),
    .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata), .o_m0_err(m0_err),
    .i_m1_req(req[1]), .i_m1_we(we[1]), .i_m1_strb(strb[1]),
    .i_m1_addr(addr[1]), .i_m1_wdata(wdata[1]),
    .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata), .o_m1_err(m1_err),
    .o_ram_we(ram_we), .o_ram_strb(ram_strb), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  // Data RAM stand-in: word storage, combinational read with extension.
  logic [31:0] ram_word[0:63];
  logic [31:0] rd_w;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  always_comb begin
    rd_w = ram_word[ram_addr[7:2]];
    rd_b = rd_w[8*ram_addr[1:0] +: 8];
    rd_h = rd_w[16*ram_addr[1] +: 16];
    case (ram_strb)
      3'b011:  ram_rdata = {{24{rd_b[7]}}, rd_b};
      3'b100:  ram_rdata = {{16{rd_h[15]}}, rd_h};
      3'b110:  ram_rdata = {24'h0, rd_b};
      3'b111:  ram_rdata = {16'h0, rd_h};
      default: ram_rdata = rd_w;
    endcase
  end
  always @(posedge clk) begin
    if (ram_we) begin
      case (ram_strb)
        3'b000:  ram_word[ram_addr[7:2]][8*ram_addr[1:0] +: 8] <= ram_wdata[8*ram_addr[1:0] +: 8];
        3'b001:  ram_word[ram_addr[7:2]][16*ram_addr[1] +: 16] <= ram_wdata[16*ram_addr[1] +: 16];
        default: ram_word[ram_addr[7:2]] <= ram_wdata;
      endcase
    end
  end

  // Reference model state
  logic [7:0]  ref_mem[0:255];
  int          wait1;
  logic        exp_rvalid[2];
  logic        exp_err[2];
  logic [31:0] exp_rdata[2];
  logic        last_g0, last_g1;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic w, input logic [2:0] s);
    if (w) return (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
    case (s)
      3'd0, 3'd3, 3'd6: return 1;
      3'd1, 3'd4, 3'd7: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] s, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = acc_size(1'b0, s);
    v  = 32'h0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_mem[(a[7:0] + k) % 256];
    if (s == 3'd3 && v[7])  v[31:8]  = 24'hFFFFFF;
    if (s == 3'd4 && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  task automatic model_reset();
    wait1 = 0;
    for (int p = 0; p < 2; p++) begin
      exp_rvalid[p] = 1'b0; exp_err[p] = 1'b0; exp_rdata[p] = 32'h0;
    end
  endtask

  // One clock: combinational checks before the edge, responses after it.
  task automatic cycle(input string tag);
    int          w;
    int          sz;
    logic        mis;
    logic [31:0] ld;
    w = -1; mis = 1'b0; ld = 32'h0;
    if (rstn) begin
      if (req[1] && (!req[0] || wait1 >= STARVE_MAX)) w = 1;
      else if (req[0]) w = 0;
    end
    #1;
    last_g0 = m0_gnt;
    last_g1 = m1_gnt;
    chk({tag, ".gnt0"}, {31'h0, m0_gnt}, {31'h0, w == 0});
    chk({tag, ".gnt1"}, {31'h0, m1_gnt}, {31'h0, w == 1});
    if (w >= 0) begin
      sz  = acc_size(we[w], strb[w]);
      mis = (addr[w] % sz) != 0;
      if (!we[w] && !mis) ld = ref_load(strb[w], addr[w]);
      chk({tag, ".ram_we"},    {31'h0, ram_we}, {31'h0, we[w] && !mis});
      chk({tag, ".ram_addr"},  ram_addr,  addr[w]);
      chk({tag, ".ram_strb"},  {29'h0, ram_strb}, {29'h0, strb[w]});
      chk({tag, ".ram_wdata"}, ram_wdata, wdata[w]);
    end else begin
      chk({tag, ".ram_we"},    {31'h0, ram_we}, 32'h0);
      chk({tag, ".ram_addr"},  ram_addr,  32'h0);
      chk({tag, ".ram_wdata"}, ram_wdata, 32'h0);
    end
    @(posedge clk);
    #1;
    if (!rstn) begin
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        exp_rvalid[p] = (w == p);
        exp_err[p]    = (w == p) && mis;
        if (w == p) exp_rdata[p] = ld;
      end
      if (w >= 0 && we[w] && !mis) begin
        for (int k = 0; k < sz; k++)
          ref_mem[addr[w][7:0] + k] = wdata[w][8*((addr[w][1:0] + k) % 4) +: 8];
      end
      if (!req[1] || w == 1) wait1 = 0;
      else if (wait1 < STARVE_MAX) wait1++;
    end
    chk({tag, ".m0_rvalid"}, {31'h0, m0_rvalid}, {31'h0, exp_rvalid[0]});
    chk({tag, ".m1_rvalid"}, {31'h0, m1_rvalid}, {31'h0, exp_rvalid[1]});
    chk({tag, ".m0_err"},    {31'h0, m0_err},    {31'h0, exp_err[0]});
    chk({tag, ".m1_err"},    {31'h0, m1_err},    {31'h0, exp_err[1]});
    chk({tag, ".m0_rdata"},  m0_rdata, exp_rdata[0]);
    chk({tag, ".m1_rdata"},  m1_rdata, exp_rdata[1]);
  endtask

  task automatic set_port(input int p, input logic r, input logic w_, input logic [2:0] s,
                          input logic [31:0] a, input logic [31:0] d);
    req[p] = r; we[p] = w_; strb[p] = s; addr[p] = a; wdata[p] = d;
  endtask

  task automatic rand_port(input int p);
    we[p]    = 1'($urandom_range(0, 1));
    strb[p]  = we[p] ? (($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                     : 3'($urandom_range(0, 2)))
                     : 3'($urandom_range(3, 7));
    addr[p]  = {24'h0, 8'($urandom_range(0, 255))};
    wdata[p] = $urandom;
    req[p]   = ($urandom_range(0, 3) != 0);
  endtask

  logic [31:0] prior;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_word[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = ram_word[i][8*k +: 8];
    end
    model_reset();

    // Reset with random inputs
    rstn = 1'b0;
    rand_port(0); rand_port(1); req[0] = 1'b1; req[1] = 1'b1;
    cycle("rst0");
    rand_port(0); rand_port(1);
    cycle("rst1");
    rstn = 1'b1;
    set_port(0, 0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0, 0);
    cycle("idle");

    // Port 0 store then load
    set_port(0, 1, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    cycle("p0_sw");
    set_port(0, 1, 0, 3'b101, 32'h10, 32'h0);
    cycle("p0_lw");
    chk("p0_lw.const", m0_rdata, 32'hDEADBEEF);
    set_port(0, 0, 0, 0, 0, 0);

    // Byte lanes through port 1
    set_port(1, 1, 1, 3'b000, 32'h21, 32'h0000A500);
    cycle("p1_sb");
    set_port(1, 1, 0, 3'b011, 32'h21, 32'h0);
    cycle("p1_lb");
    chk("p1_lb.const", m1_rdata, 32'hFFFFFFA5);
    set_port(1, 1, 0, 3'b110, 32'h21, 32'h0);
    cycle("p1_lbu");
    chk("p1_lbu.const", m1_rdata, 32'h000000A5);
    set_port(1, 0, 0, 0, 0, 0);
    cycle("gap");

    // Sustained contention
    set_port(0, 1, 0, 3'b101, 32'h10, 32'h0);
    set_port(1, 1, 0, 3'b101, 32'h20, 32'h0);
    for (int i = 1; i <= 15; i++) begin
      cycle($sformatf("cont%0d", i));
      chk($sformatf("cont%0d.m1_pattern", i), {31'h0, last_g1}, {31'h0, (i % 5) == 0});
      chk($sformatf("cont%0d.one_hot", i), {31'h0, last_g0 && last_g1}, 32'h0);
    end
    set_port(0, 0, 0, 0, 0, 0);

    // Misalignment
    set_port(1, 1, 0, 3'b101, 32'h13, 32'h0);
    cycle("mis_lw");
    chk("mis_lw.err", {31'h0, m1_err}, 32'h1);
    chk("mis_lw.rdata", m1_rdata, 32'h0);
    set_port(1, 1, 1, 3'b010, 32'h12, 32'h12345678);
    cycle("mis_sw");
    set_port(1, 1, 0, 3'b101, 32'h10, 32'h0);
    cycle("mis_rb");
    chk("mis_rb.const", m1_rdata, 32'hDEADBEEF);
    set_port(1, 0, 0, 0, 0, 0);
    cycle("gap2");

    // Reset during a pending write
    prior = ref_load(3'b101, 32'h40);
    set_port(1, 1, 1, 3'b010, 32'h40, 32'h55);
    #2;
    rstn = 1'b0;
    cycle("rst_wr");
    chk("rst_wr.rvalid", {31'h0, m1_rvalid}, 32'h0);
    rstn = 1'b1;
    set_port(1, 1, 0, 3'b101, 32'h40, 32'h0);
    cycle("rst_rb");
    chk("rst_rb.prior", m1_rdata, prior);
    set_port(1, 0, 0, 0, 0, 0);

    // Random traffic; a request is held until it is granted
    rand_port(0); rand_port(1);
    for (int i = 0; i < 400; i++) begin
      cycle($sformatf("rnd%0d", i));
      if (last_g0 || !req[0]) rand_port(0);
      if (last_g1 || !req[1]) rand_port(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
